// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for the 32x32 register file: pipeline writeback vs. a FIFO-buffered mul/div unit.
// Define RF_ARB_BYPASS_EN to let MD results skip an empty FIFO when the write port is idle.
module rf_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int PTR_W        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_we,
  input  logic [4:0]       wb_wn,
  input  logic [31:0]      wb_wd,
  output logic             wb_stall,
  input  logic             md_valid,
  input  logic [4:0]       md_wn,
  input  logic [31:0]      md_wd,
  output logic             md_ready,
  input  logic [4:0]       q_rn1,
  input  logic [4:0]       q_rn2,
  output logic             q_busy1,
  output logic             q_busy2,
  output logic             rf_we,
  output logic [4:0]       rf_wn,
  output logic [31:0]      rf_wd,
  output logic [PTR_W:0]   pend_cnt
);

  typedef enum logic {ST_NORM, ST_FORCE} state_t;

  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [7:0]     STARVE_MAX = 8'(STARVE_LIMIT);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic [7:0]         starve_q, starve_d;
  logic [DEPTH-1:0]   live_q, live_d;
  logic [4:0]         wn_q [DEPTH];
  logic [4:0]         wn_d [DEPTH];
  logic [31:0]        wd_q [DEPTH];
  logic [31:0]        wd_d [DEPTH];
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_wn_q, rf_wn_d;
  logic [31:0]        rf_wd_q, rf_wd_d;
  logic               wb_stall_q, wb_stall_d;

  logic fifo_empty;
  logic wb_grant;
  logic md_grant;
  logic pop;
  logic push;
  logic byp;

  assign md_ready = (cnt_q != FULL_CNT);

  // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    wb_grant   = (state_q == ST_NORM) && wb_we && (wb_wn != 5'd0);
    pop        = !fifo_empty && ((state_q == ST_FORCE) || !wb_grant);
    md_grant   = pop && live_q[rd_ptr_q];
`ifdef RF_ARB_BYPASS_EN
    byp        = (state_q == ST_NORM) && fifo_empty && !wb_grant &&
                 md_valid && (md_wn != 5'd0);
`else
    byp        = 1'b0;
`endif
    push       = md_valid && md_ready && (md_wn != 5'd0) && !byp;
  end

  // FIFO bookkeeping; a popped slot loses its live bit so queries only need live_q.
  always_comb begin
    live_d   = live_q;
    wn_d     = wn_q;
    wd_d     = wd_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    if (wb_grant) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wn_q[i] == wb_wn) live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end
    // Applied after the kill so a same-cycle push of the same register stays live.
    if (push) begin
      wn_d[wr_ptr_q]   = md_wn;
      wd_d[wr_ptr_q]   = md_wd;
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d  = ST_NORM;
    starve_d = starve_q;
    if (state_q == ST_FORCE || fifo_empty || pop) begin
      starve_d = 8'd0;
    end else if (wb_grant) begin
      starve_d = starve_q + 1'b1;
      if (starve_d == STARVE_MAX) state_d = ST_FORCE;
    end
    wb_stall_d = (state_d == ST_FORCE);
  end

  always_comb begin
    rf_we_d = wb_grant || md_grant || byp;
    rf_wn_d = rf_wn_q;
    rf_wd_d = rf_wd_q;
    if (wb_grant) begin
      rf_wn_d = wb_wn;
      rf_wd_d = wb_wd;
    end else if (md_grant) begin
      rf_wn_d = wn_q[rd_ptr_q];
      rf_wd_d = wd_q[rd_ptr_q];
    end else if (byp) begin
      rf_wn_d = md_wn;
      rf_wd_d = md_wd;
    end
  end

  always_comb begin
    q_busy1 = 1'b0;
    q_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (wn_q[i] == q_rn1) && (q_rn1 != 5'd0)) q_busy1 = 1'b1;
      if (live_q[i] && (wn_q[i] == q_rn2) && (q_rn2 != 5'd0)) q_busy2 = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_NORM;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= 8'd0;
      live_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_wn_q    <= 5'd0;
      rf_wd_q    <= 32'd0;
      wb_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      live_q     <= live_d;
      rf_we_q    <= rf_we_d;
      rf_wn_q    <= rf_wn_d;
      rf_wd_q    <= rf_wd_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  // NOTE: payload storage has no reset; the live bits and count alone decide what is valid.
  always_ff @(posedge clk) begin
    wn_q <= wn_d;
    wd_q <= wd_d;
  end

  assign rf_we    = rf_we_q;
  assign rf_wn    = rf_wn_q;
  assign rf_wd    = rf_wd_q;
  assign wb_stall = wb_stall_q;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: a cycle-by-cycle vector table plus starvation and reset-mid-drain sequences.
module tb_rf_wr_arbiter;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wb_we;
  logic [4:0]       wb_wn;
  logic [31:0]      wb_wd;
  logic             wb_stall;
  logic             md_valid;
  logic [4:0]       md_wn;
  logic [31:0]      md_wd;
  logic             md_ready;
  logic [4:0]       q_rn1;
  logic [4:0]       q_rn2;
  logic             q_busy1;
  logic             q_busy2;
  logic             rf_we;
  logic [4:0]       rf_wn;
  logic [31:0]      rf_wd;
  logic [PTR_W:0]   pend_cnt;

  rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_we    (wb_we),
    .wb_wn    (wb_wn),
    .wb_wd    (wb_wd),
    .wb_stall (wb_stall),
    .md_valid (md_valid),
    .md_wn    (md_wn),
    .md_wd    (md_wd),
    .md_ready (md_ready),
    .q_rn1    (q_rn1),
    .q_rn2    (q_rn2),
    .q_busy1  (q_busy1),
    .q_busy2  (q_busy2),
    .rf_we    (rf_we),
    .rf_wn    (rf_wn),
    .rf_wd    (rf_wd),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst_n;
    logic           wb_we;
    logic [4:0]     wb_wn;
    logic [31:0]    wb_wd;
    logic           md_valid;
    logic [4:0]     md_wn;
    logic [31:0]    md_wd;
    logic [4:0]     q_rn1;
    logic [4:0]     q_rn2;
    logic           e_we;
    logic [4:0]     e_wn;
    logic [31:0]    e_wd;
    logic           e_stall;
    logic           e_ready;
    logic [PTR_W:0] e_pend;
    logic           e_busy1;
    logic           e_busy2;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, we, input logic [4:0] wn, input logic [31:0] wd,
                     input logic mv, input logic [4:0] mwn, input logic [31:0] mwd,
                     input logic [4:0] r1, r2,
                     input logic e_we, input logic [4:0] e_wn, input logic [31:0] e_wd,
                     input logic e_st, e_rdy, input logic [PTR_W:0] e_pend,
                     input logic e_b1, e_b2);
    vec_t v;
    v.rst_n = r;    v.wb_we = we;      v.wb_wn = wn;   v.wb_wd = wd;
    v.md_valid = mv; v.md_wn = mwn;    v.md_wd = mwd;
    v.q_rn1 = r1;   v.q_rn2 = r2;
    v.e_we = e_we;  v.e_wn = e_wn;     v.e_wd = e_wd;  v.e_stall = e_st;
    v.e_ready = e_rdy; v.e_pend = e_pend; v.e_busy1 = e_b1; v.e_busy2 = e_b2;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then sample just after the rising edge.
  task automatic step(input logic r, we, input logic [4:0] wn, input logic [31:0] wd,
                      input logic mv, input logic [4:0] mwn, input logic [31:0] mwd,
                      input logic [4:0] r1, r2);
    @(negedge clk);
    rst_n = r;  wb_we = we;  wb_wn = wn;  wb_wd = wd;
    md_valid = mv;  md_wn = mwn;  md_wd = mwd;
    q_rn1 = r1;  q_rn2 = r2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wb_we = 1'b0; wb_wn = '0; wb_wd = '0;
    md_valid = 1'b0; md_wn = '0; md_wd = '0; q_rn1 = '0; q_rn2 = '0;

    // reset for two edges
    add(0,0,0,0,       0,0,0,        0,0,   0,0,0,       0,1,0,0,0);
    add(0,0,0,0,       0,0,0,        0,0,   0,0,0,       0,1,0,0,0);
    // first MD push with WB idle
`ifdef RF_ARB_BYPASS_EN
    add(1,0,0,0,       1,5,'h11,     5,0,   1,5,'h11,    0,1,0,0,0);
    add(1,0,0,0,       0,0,0,        5,0,   0,5,'h11,    0,1,0,0,0);
`else
    add(1,0,0,0,       1,5,'h11,     5,0,   0,0,0,       0,1,1,1,0);
    add(1,0,0,0,       0,0,0,        5,0,   1,5,'h11,    0,1,0,0,0);
`endif
    add(1,0,0,0,       0,0,0,        0,0,   0,5,'h11,    0,1,0,0,0);
    // fill the FIFO while WB writes r1..r4, then a refused 5th push
    add(1,1,1,'hA1,    1,20,'h120,   20,0,  1,1,'hA1,    0,1,1,1,0);
    add(1,1,2,'hA2,    1,21,'h121,   20,21, 1,2,'hA2,    0,1,2,1,1);
    add(1,1,3,'hA3,    1,22,'h122,   20,22, 1,3,'hA3,    0,1,3,1,1);
    add(1,1,4,'hA4,    1,23,'h123,   20,23, 1,4,'hA4,    0,0,4,1,1);
    add(1,1,5,'hA5,    1,24,'h124,   24,23, 1,5,'hA5,    0,0,4,0,1);
    // WB idles: drain in FIFO order
    add(1,0,0,0,       0,0,0,        20,21, 1,20,'h120,  0,1,3,0,1);
    add(1,0,0,0,       0,0,0,        21,22, 1,21,'h121,  0,1,2,0,1);
    add(1,0,0,0,       0,0,0,        22,23, 1,22,'h122,  0,1,1,0,1);
    add(1,0,0,0,       0,0,0,        23,0,  1,23,'h123,  0,1,0,0,0);
    add(1,0,0,0,       0,0,0,        0,0,   0,23,'h123,  0,1,0,0,0);
    // WAW: queued r7=AA killed by WB r7=BB, dead entry pops silently
    add(1,1,8,'h88,    1,7,'hAA,     7,0,   1,8,'h88,    0,1,1,1,0);
    add(1,1,7,'hBB,    0,0,0,        7,0,   1,7,'hBB,    0,1,1,0,0);
    add(1,0,0,0,       0,0,0,        7,0,   0,7,'hBB,    0,1,0,0,0);
    // WAW with a same-cycle younger push of the same register
    add(1,1,8,'h01,    1,7,'hD1,     7,0,   1,8,'h01,    0,1,1,1,0);
    add(1,1,7,'hCC,    1,7,'hDD,     7,0,   1,7,'hCC,    0,1,2,1,0);
    add(1,0,0,0,       0,0,0,        7,0,   0,7,'hCC,    0,1,1,1,0);
    add(1,0,0,0,       0,0,0,        7,0,   1,7,'hDD,    0,1,0,0,0);
    // register zero from either writer is never written
    add(1,0,0,0,       1,0,'h55,     0,0,   0,7,'hDD,    0,1,0,0,0);
    add(1,1,0,'h66,    0,0,0,        0,0,   0,7,'hDD,    0,1,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst_n, vq[i].wb_we, vq[i].wb_wn, vq[i].wb_wd,
           vq[i].md_valid, vq[i].md_wn, vq[i].md_wd, vq[i].q_rn1, vq[i].q_rn2);
      check($sformatf("v%0d rf_we", i),    32'(rf_we),    32'(vq[i].e_we));
      check($sformatf("v%0d rf_wn", i),    32'(rf_wn),    32'(vq[i].e_wn));
      check($sformatf("v%0d rf_wd", i),    rf_wd,         vq[i].e_wd);
      check($sformatf("v%0d wb_stall", i), 32'(wb_stall), 32'(vq[i].e_stall));
      check($sformatf("v%0d md_ready", i), 32'(md_ready), 32'(vq[i].e_ready));
      check($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(vq[i].e_pend));
      check($sformatf("v%0d q_busy1", i),  32'(q_busy1),  32'(vq[i].e_busy1));
      check($sformatf("v%0d q_busy2", i),  32'(q_busy2),  32'(vq[i].e_busy2));
    end

    // Starvation: r9 waits while WB writes r10 every cycle.
    step(1,1,10,'h10, 1,9,'h1, 9,0);
    check("starve push rf_wn", 32'(rf_wn), 32'd10);
    check("starve push pend",  32'(pend_cnt), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step(1,1,10,'h10, 0,0,0, 9,0);
      check($sformatf("starve k%0d wb_stall", k), 32'(wb_stall), 32'(k == 8));
      check($sformatf("starve k%0d rf_wn", k),    32'(rf_wn),    32'd10);
    end
    // forced slot: held WB ignored, r9 written
    step(1,1,10,'h10, 0,0,0, 9,0);
    check("force rf_we",    32'(rf_we),    32'd1);
    check("force rf_wn",    32'(rf_wn),    32'd9);
    check("force rf_wd",    rf_wd,         32'h1);
    check("force wb_stall", 32'(wb_stall), 32'd0);
    check("force pend",     32'(pend_cnt), 32'd0);
    check("force q_busy1",  32'(q_busy1),  32'd0);
    step(1,1,10,'h10, 0,0,0, 0,0);
    check("resume rf_wn",    32'(rf_wn),    32'd10);
    check("resume wb_stall", 32'(wb_stall), 32'd0);

    // Reset mid-drain discards three queued results.
    step(1,1,1,'hE1, 1,11,'h211, 11,13);
    step(1,1,2,'hE2, 1,12,'h212, 11,13);
    step(1,1,3,'hE3, 1,13,'h213, 11,13);
    check("pre-reset pend",  32'(pend_cnt), 32'd3);
    check("pre-reset busy2", 32'(q_busy2),  32'd1);
    step(0,0,0,0, 0,0,0, 11,13);
    check("mid reset rf_we", 32'(rf_we),    32'd0);
    check("mid reset rf_wn", 32'(rf_wn),    32'd0);
    check("mid reset rf_wd", rf_wd,         32'd0);
    check("mid reset pend",  32'(pend_cnt), 32'd0);
    check("mid reset busy1", 32'(q_busy1),  32'd0);
    check("mid reset ready", 32'(md_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1,0,0,0, 0,0,0, 11,13);
      check($sformatf("post reset %0d rf_we", k), 32'(rf_we),    32'd0);
      check($sformatf("post reset %0d pend", k),  32'(pend_cnt), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
